pgen_multi: RTL and testbench

Multi-channel, runtime-programmable pulse generator. One shared period counter drives N_CH independent output channels. Each channel has its own phase, width, mode and burst length, written through a simple register port. New settings take effect glitch-free at the period boundary. The block sits where fixed-parameter pulse generators were used, and adds wrap-around pulses, burst/one-shot modes and a sync chain (sync_in/sync_out) for cascading several instances.

---
 rtl/pgen_pkg.sv | 31 +++
 rtl/pgen_ch.sv | 132 +++++++++++++
 rtl/pgen_multi.sv | 102 ++++++++++
 tb/tb_pgen_multi.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pgen_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pgen_pkg : shared types and constants for the pgen_multi pulse generator
// Rev 1.0
// ---------------------------------------------------------------------------
package pgen_pkg;

   localparam int c_cnt_w_def   = 16;
   localparam int c_burst_w_def = 8;

   localparam logic [2:0] c_addr_period = 3'd0;
   localparam logic [2:0] c_addr_phase  = 3'd1;
   localparam logic [2:0] c_addr_width  = 3'd2;
   localparam logic [2:0] c_addr_mode   = 3'd3;
   localparam logic [2:0] c_addr_burst  = 3'd4;

   typedef enum logic [1:0] {
      MODE_OFF   = 2'd0,
      MODE_CONT  = 2'd1,
      MODE_BURST = 2'd2
   } mode_e;

   typedef enum logic [1:0] {
      BST_IDLE  = 2'd0,
      BST_ARMED = 2'd1,
      BST_RUN   = 2'd2,
      BST_DONE  = 2'd3
   } bst_e;

endpackage
`default_nettype wire

// File: rtl/pgen_ch.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pgen_ch : one output channel - shadow/active settings, modular distance
//           compare, burst state machine and the registered pulse output
// Rev 1.0
// ---------------------------------------------------------------------------
module pgen_ch
   import pgen_pkg::*;
#(
   parameter int CNT_W   = c_cnt_w_def,
   parameter int BURST_W = c_burst_w_def
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [CNT_W-1:0] cnt,
   input  logic [CNT_W-1:0] period,
   input  logic [CNT_W-1:0] period_nxt,
   input  logic             bnd,
   input  logic             we_phase,
   input  logic             we_width,
   input  logic             we_mode,
   input  logic             we_burst,
   input  logic [CNT_W-1:0] wdata,
   output logic             pls,
   output logic             done
);

   localparam logic [BURST_W-1:0] c_pcnt_one = BURST_W'(1);

   logic [CNT_W-1:0]   r_phase_sh, r_width_sh, r_phase, r_width;
   mode_e              r_mode_sh, r_mode;
   logic [BURST_W-1:0] r_blen_sh, r_blen, r_pcnt;
   logic               r_mode_pend;
   bst_e               r_state;
   logic               r_pls, r_done;

   logic [CNT_W-1:0]   w_dist;
   logic [BURST_W-1:0] w_pcnt_inc;
   logic               w_raw, w_at_phase, w_pls_nxt, w_fall;

   // Both branches stay below period because the active phase is pre-reduced
   assign w_dist     = (cnt >= r_phase) ? (cnt - r_phase) : (cnt + period - r_phase);
   assign w_raw      = (w_dist < r_width);
   assign w_at_phase = (cnt == r_phase);
   assign w_pcnt_inc = r_pcnt + c_pcnt_one;
   assign w_fall     = r_pls & ~w_pls_nxt;

   always_comb begin
      w_pls_nxt = 1'b0;
      case (r_mode)
         MODE_CONT:  w_pls_nxt = w_raw;
         MODE_BURST: w_pls_nxt = w_raw & ((r_state == BST_RUN) |
                                          ((r_state == BST_ARMED) & w_at_phase));
         default:    w_pls_nxt = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_phase_sh  <= '0;
         r_width_sh  <= '0;
         r_mode_sh   <= MODE_OFF;
         r_blen_sh   <= '0;
         r_mode_pend <= 1'b0;
      end else begin
         if (we_phase) r_phase_sh <= wdata;
         if (we_width) r_width_sh <= wdata;
         if (we_burst) r_blen_sh  <= wdata[BURST_W-1:0];
         // A mode write landing on bnd must survive to the following commit
         if (we_mode) begin
            r_mode_sh   <= mode_e'(wdata[1:0]);
            r_mode_pend <= 1'b1;
         end else if (bnd) begin
            r_mode_pend <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_phase <= '0;
         r_width <= '0;
         r_mode  <= MODE_OFF;
         r_blen  <= '0;
         r_pcnt  <= '0;
         r_state <= BST_IDLE;
         r_pls   <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_pls <= w_pls_nxt;
         if (bnd) begin
            r_phase <= r_phase_sh % period_nxt;
            r_width <= r_width_sh;
            r_mode  <= r_mode_sh;
            r_blen  <= r_blen_sh;
         end
         if (bnd && r_mode_pend) begin
            r_pcnt <= '0;
            r_done <= 1'b0;
            if (r_mode_sh != MODE_BURST) begin
               r_state <= BST_IDLE;
            end else if (r_blen_sh == '0) begin
               r_state <= BST_DONE;
               r_done  <= 1'b1;
            end else begin
               r_state <= BST_ARMED;
            end
         end else begin
            case (r_state)
               BST_ARMED: begin
                  if (w_at_phase && (r_mode == MODE_BURST)) r_state <= BST_RUN;
               end
               BST_RUN: begin
                  if (w_fall) begin
                     r_pcnt <= w_pcnt_inc;
                     if (w_pcnt_inc == r_blen) begin
                        r_state <= BST_DONE;
                        r_done  <= 1'b1;
                     end
                  end
               end
               default: r_state <= r_state;
            endcase
         end
      end
   end

   assign pls  = r_pls;
   assign done = r_done;

endmodule
`default_nettype wire

// File: rtl/pgen_multi.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pgen_multi : multi-channel programmable pulse generator sharing one period
//              counter, with shadowed settings committed at period boundaries
// Rev 1.0
// ---------------------------------------------------------------------------
module pgen_multi
   import pgen_pkg::*;
#(
   parameter int  N_CH         = 4,
   parameter int  CNT_W        = c_cnt_w_def,
   parameter int  BURST_W      = c_burst_w_def,
   parameter int  P_PERIOD_RST = 10,
   localparam int CH_W         = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             sync_in,
   input  logic             cfg_we,
   input  logic [CH_W-1:0]  cfg_ch,
   input  logic [2:0]       cfg_addr,
   input  logic [CNT_W-1:0] cfg_wdata,
   output logic [N_CH-1:0]  pls,
   output logic             sync_out,
   output logic [N_CH-1:0]  done,
   output logic             cfg_err
);

   localparam logic [CNT_W-1:0] c_one      = CNT_W'(1);
   localparam logic [CNT_W-1:0] c_min_per  = CNT_W'(2);
   localparam logic [CNT_W-1:0] c_mode_max = CNT_W'(MODE_BURST);
   localparam logic [CNT_W-1:0] c_per_rst  = CNT_W'(P_PERIOD_RST);
   localparam logic [CH_W:0]    c_n_ch     = (CH_W + 1)'(N_CH);

   logic [CNT_W-1:0] r_cnt, r_period, r_period_sh;
   logic             r_sync_out, r_cfg_err;
   logic             w_last, w_bnd, w_ch_ok, w_err, w_ok;

   assign w_last  = (r_cnt == r_period - c_one);
   assign w_bnd   = w_last | sync_in;
   assign w_ch_ok = ({1'b0, cfg_ch} < c_n_ch);

   always_comb begin
      w_err = 1'b0;
      case (cfg_addr)
         c_addr_period: w_err = (cfg_wdata < c_min_per);
         c_addr_phase,
         c_addr_width,
         c_addr_burst:  w_err = ~w_ch_ok;
         c_addr_mode:   w_err = ~w_ch_ok | (cfg_wdata > c_mode_max);
         default:       w_err = 1'b1;
      endcase
   end

   assign w_ok = cfg_we & ~w_err;

   // The period only changes as cnt returns to 0, so cnt never exceeds it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt       <= '0;
         r_period    <= c_per_rst;
         r_period_sh <= c_per_rst;
         r_sync_out  <= 1'b0;
         r_cfg_err   <= 1'b0;
      end else begin
         r_cnt      <= w_bnd ? '0 : r_cnt + c_one;
         r_sync_out <= w_last;
         r_cfg_err  <= cfg_we & w_err;
         if (w_bnd) r_period <= r_period_sh;
         if (w_ok && (cfg_addr == c_addr_period)) r_period_sh <= cfg_wdata;
      end
   end

   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      logic w_sel;
      assign w_sel = w_ok && (cfg_ch == CH_W'(g));

      pgen_ch #(
         .CNT_W   (CNT_W),
         .BURST_W (BURST_W)
      ) u_ch (
         .clk        (clk),
         .rst_n      (rst_n),
         .cnt        (r_cnt),
         .period     (r_period),
         .period_nxt (r_period_sh),
         .bnd        (w_bnd),
         .we_phase   (w_sel && (cfg_addr == c_addr_phase)),
         .we_width   (w_sel && (cfg_addr == c_addr_width)),
         .we_mode    (w_sel && (cfg_addr == c_addr_mode)),
         .we_burst   (w_sel && (cfg_addr == c_addr_burst)),
         .wdata      (cfg_wdata),
         .pls        (pls[g]),
         .done       (done[g])
      );
   end

   assign sync_out = r_sync_out;
   assign cfg_err  = r_cfg_err;

endmodule
`default_nettype wire

// File: tb/tb_pgen_multi.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_pgen_multi : randomized and directed bench for pgen_multi against a
//                 behavioural reference model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_pgen_multi;

   localparam int N  = 3;   // three channels so cfg_ch = N_CH is encodable
   localparam int CW = 16;
   localparam int BW = 8;
   localparam int PR = 10;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          sync_in = 1'b0;
   logic          cfg_we = 1'b0;
   logic [1:0]    cfg_ch = '0;
   logic [2:0]    cfg_addr = '0;
   logic [CW-1:0] cfg_wdata = '0;
   logic [N-1:0]  pls, done;
   logic          sync_out, cfg_err;

   pgen_multi #(.N_CH(N), .CNT_W(CW), .BURST_W(BW), .P_PERIOD_RST(PR)) dut (
      .clk(clk), .rst_n(rst_n), .sync_in(sync_in), .cfg_we(cfg_we),
      .cfg_ch(cfg_ch), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
      .pls(pls), .sync_out(sync_out), .done(done), .cfg_err(cfg_err)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   // reference model state: counter, periods, active/shadow settings, burst progress
   int m_cnt, m_per, s_per;
   int a_ph[N], a_wd[N], a_md[N], a_bl[N];
   int s_ph[N], s_wd[N], s_md[N], s_bl[N];
   bit s_mw[N], b_wait[N], b_run[N];
   int pc[N];
   bit e_pls[N], e_done[N];
   bit e_sync, e_err;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   task automatic model_reset();
      m_cnt = 0; m_per = PR; s_per = PR;
      for (int c = 0; c < N; c++) begin
         a_ph[c] = 0; a_wd[c] = 0; a_md[c] = 0; a_bl[c] = 0;
         s_ph[c] = 0; s_wd[c] = 0; s_md[c] = 0; s_bl[c] = 0;
         s_mw[c] = 0; b_wait[c] = 0; b_run[c] = 0; pc[c] = 0;
         e_pls[c] = 0; e_done[c] = 0;
      end
      e_sync = 0; e_err = 0;
   endtask

   // advance the model by one clock using the inputs currently applied
   task automatic model_step();
      bit last, bnd, bad, raw;
      bit nxt[N];
      int d, ch;
      if (!rst_n) begin
         model_reset();
         return;
      end
      last = (m_cnt == m_per - 1);
      bnd  = last || sync_in;
      for (int c = 0; c < N; c++) begin
         d   = (m_cnt - a_ph[c] + m_per) % m_per;
         raw = (d < a_wd[c]);
         nxt[c] = 0;
         if (a_md[c] == 1) nxt[c] = raw;
         else if (a_md[c] == 2) nxt[c] = raw && (b_run[c] || (b_wait[c] && m_cnt == a_ph[c]));
         if (bnd && s_mw[c]) begin
            e_done[c] = 0; pc[c] = 0; b_run[c] = 0;
            b_wait[c] = (s_md[c] == 2) && (s_bl[c] != 0);
            if (s_md[c] == 2 && s_bl[c] == 0) e_done[c] = 1;
         end else if (b_wait[c] && a_md[c] == 2 && m_cnt == a_ph[c]) begin
            b_wait[c] = 0; b_run[c] = 1;
         end else if (b_run[c] && e_pls[c] && !nxt[c]) begin
            pc[c]++;
            if (pc[c] == a_bl[c]) begin
               b_run[c] = 0; e_done[c] = 1;
            end
         end
         e_pls[c] = nxt[c];
      end
      if (bnd) begin
         m_per = s_per;
         for (int c = 0; c < N; c++) begin
            a_ph[c] = s_ph[c] % s_per;
            a_wd[c] = s_wd[c]; a_md[c] = s_md[c]; a_bl[c] = s_bl[c];
            s_mw[c] = 0;
         end
      end
      e_err = 0;
      if (cfg_we) begin
         ch  = int'(cfg_ch);
         bad = (cfg_addr > 4) ||
               ((cfg_addr == 0) ? (cfg_wdata < 2) : ((ch >= N) || (cfg_addr == 3 && cfg_wdata > 2)));
         e_err = bad;
         if (!bad) begin
            case (cfg_addr)
               3'd0: s_per = int'(cfg_wdata);
               3'd1: s_ph[ch] = int'(cfg_wdata);
               3'd2: s_wd[ch] = int'(cfg_wdata);
               3'd3: begin s_md[ch] = int'(cfg_wdata); s_mw[ch] = 1; end
               default: s_bl[ch] = int'(cfg_wdata) % 256;
            endcase
         end
      end
      e_sync = last;
      m_cnt  = bnd ? 0 : m_cnt + 1;
   endtask

   task automatic step();
      logic [N-1:0] ep, ed;
      model_step();
      @(posedge clk);
      #1;
      for (int c = 0; c < N; c++) begin
         ep[c] = e_pls[c];
         ed[c] = e_done[c];
      end
      check("pls", 32'(pls), 32'(ep));
      check("done", 32'(done), 32'(ed));
      check("sync_out", 32'(sync_out), 32'(e_sync));
      check("cfg_err", 32'(cfg_err), 32'(e_err));
   endtask

   task automatic wr(input int ch, input int addr, input int data);
      cfg_we = 1'b1; cfg_ch = 2'(ch); cfg_addr = 3'(addr); cfg_wdata = CW'(data);
      step();
      cfg_we = 1'b0;
   endtask

   task automatic count_to_sync(output int k);
      k = 0;
      do begin
         step();
         k++;
      end while (!sync_out && k < 100);
      check("sync_seen", 32'(sync_out), 32'd1);
   endtask

   task automatic wait_sync();
      int k;
      count_to_sync(k);
   endtask

   task automatic wait_cnt(input int v);
      for (int k = 0; k < 100 && m_cnt != v; k++) step();
   endtask

   task automatic count_high(input int ch, input int cycles, output int n);
      n = 0;
      for (int k = 0; k < cycles; k++) begin
         step();
         if (pls[ch]) n++;
      end
   endtask

   task automatic count_rise(input int ch, input int cycles, output int n);
      logic prev;
      n = 0;
      prev = pls[ch];
      for (int k = 0; k < cycles; k++) begin
         step();
         if (pls[ch] && !prev) n++;
         prev = pls[ch];
      end
   endtask

   initial begin
      int n, r, ch, addr, data;
      model_reset();
      repeat (3) step();
      rst_n = 1'b1;

      // reset defaults: silent outputs, sync_out every 10 cycles
      n = 0;
      for (int k = 0; k < 30; k++) begin
         step();
         if (sync_out) n++;
      end
      check("rst_sync_count", 32'(n), 32'd3);

      // continuous pulse, phase 2 width 3
      wr(0, 1, 2); wr(0, 2, 3); wr(0, 3, 1);
      wait_sync(); wait_sync();
      count_high(0, 20, n);
      check("cont_high", 32'(n), 32'd6);

      // wrap-around pulse and the width extremes
      wr(0, 0, 8); wr(1, 1, 6); wr(1, 2, 4); wr(1, 3, 1);
      wait_sync(); wait_sync();
      count_high(1, 16, n);
      check("wrap_high", 32'(n), 32'd8);
      wr(1, 2, 8);
      wait_sync(); wait_sync();
      count_high(1, 16, n);
      check("wide_high", 32'(n), 32'd16);
      wr(1, 2, 0);
      wait_sync(); wait_sync();
      count_high(1, 16, n);
      check("zero_high", 32'(n), 32'd0);

      // burst of three, then re-arm
      wr(2, 2, 2); wr(2, 4, 3); wr(2, 1, 1); wr(2, 3, 2);
      count_rise(2, 80, n);
      check("burst1_pulses", 32'(n), 32'd3);
      check("burst1_done", 32'(done[2]), 32'd1);
      wait_cnt(2);
      wr(2, 3, 2);
      wait_sync();
      check("burst_rearm_done", 32'(done[2]), 32'd0);
      count_rise(2, 80, n);
      check("burst2_pulses", 32'(n), 32'd3);
      check("burst2_done", 32'(done[2]), 32'd1);

      // period change mid-period, then sync_in truncating ch0's pulse
      wr(0, 0, 10);
      wait_sync(); wait_sync();
      wait_cnt(4);
      wr(0, 0, 6);
      wait_sync();
      count_to_sync(n);
      check("new_period", 32'(n), 32'd6);
      wait_cnt(3);
      sync_in = 1'b1;
      step();
      sync_in = 1'b0;
      count_to_sync(n);
      check("sync_restart", 32'(n), 32'd6);

      // rejected writes
      wr(0, 0, 1);
      check("err_period", 32'(cfg_err), 32'd1);
      wr(0, 3, 3);
      check("err_mode", 32'(cfg_err), 32'd1);
      wr(3, 1, 5);
      check("err_ch", 32'(cfg_err), 32'd1);
      repeat (12) step();

      // reset mid-operation
      rst_n = 1'b0;
      repeat (2) step();
      rst_n = 1'b1;
      repeat (25) step();

      // randomized writes and sync pulses
      for (int it = 0; it < 3000; it++) begin
         r = $urandom_range(0, 99);
         if (r < 12) begin
            ch   = $urandom_range(0, 3);
            addr = $urandom_range(0, 5);
            case (addr)
               0:       data = $urandom_range(0, 12);
               3:       data = (r < 6) ? 2 : $urandom_range(0, 3);
               4:       data = $urandom_range(0, 4);
               5:       data = $urandom_range(0, 15);
               default: data = $urandom_range(0, 14);
            endcase
            cfg_we = 1'b1; cfg_ch = 2'(ch); cfg_addr = 3'(addr); cfg_wdata = CW'(data);
         end else if (r < 15) begin
            sync_in = 1'b1;
         end
         step();
         cfg_we  = 1'b0;
         sync_in = 1'b0;
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
